key_chunk_dispatcher: RTL

Dynamic work dispatcher that sits directly upstream of the RC4 cracking cores. After a start pulse it hands out contiguous key-range chunks, one grant per cycle, to whichever cores request work, using round-robin arbitration. It halts on a stop from the downstream key selector, or once the search space is exhausted. It replaces the fixed per-core BEGIN_SEARCH/END_SEARCH partitioning, so a core that finishes early immediately picks up new work.

---
 rtl/key_chunk_dispatcher.sv | 133 +++++++++++++
 1 files changed

// File: rtl/key_chunk_dispatcher.sv
// Round-robin dispatcher of contiguous key-range chunks to idle cracking cores; one grant per cycle.
// Latency: req sampled at edge M yields a registered grant pulse after M. No backpressure: idle cores wait on req.
module key_chunk_dispatcher #(
    parameter int                      NUM_CORES    = 4,
    parameter int                      KEY_WIDTH    = 22,
    parameter int                      CHUNK_BITS   = 16,
    parameter logic [KEY_WIDTH-1:0]    BEGIN_SEARCH = 22'h000000,
    parameter logic [KEY_WIDTH-1:0]    END_SEARCH   = 22'h3FFFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NUM_CORES-1:0]    core_req,
    output logic [NUM_CORES-1:0]    grant,
    output logic [KEY_WIDTH-1:0]    chunk_base,
    output logic [KEY_WIDTH-1:0]    chunk_end,
    output logic                    busy,
    output logic                    done,
    output logic                    exhausted,
    output logic [15:0]             chunks_issued
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [KEY_WIDTH:0] CHUNK_SIZE = {{KEY_WIDTH{1'b0}}, 1'b1} << CHUNK_BITS;
    localparam logic [KEY_WIDTH:0] CHUNK_MAX  = CHUNK_SIZE - 1'b1;
    localparam logic [KEY_WIDTH:0] END_EXT    = {1'b0, END_SEARCH};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPED,
        S_EXHAUSTED
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [KEY_WIDTH:0]     next_base;
    logic [PTR_W-1:0]       rr_ptr;
    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   rotated;
    logic [NUM_CORES-1:0]   pick_onehot;
    logic                   pick_vld;
    int                     pick_idx;
    logic [PTR_W-1:0]       pick_ptr_nxt;
    logic [KEY_WIDTH:0]     end_sum;
    logic [KEY_WIDTH-1:0]   end_clip;
    logic                   last_chunk;
    logic                   do_grant;
    logic                   do_init;

    // Masking the live grant keeps a core from being re-granted while it still sees its pulse.
    always_comb begin
        eligible = core_req & ~grant;
        rotated  = NUM_CORES'({eligible, eligible} >> rr_ptr);
        pick_vld = 1'b0;
        pick_idx = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!pick_vld && rotated[i]) begin
                pick_vld = 1'b1;
                pick_idx = (int'(rr_ptr) + i) % NUM_CORES;
            end
        end
        pick_onehot  = pick_vld ? (NUM_CORES'(1) << pick_idx) : '0;
        pick_ptr_nxt = PTR_W'((pick_idx + 1) % NUM_CORES);
    end

    // One extra bit of headroom so the chunk sum never wraps past the top of the key space.
    always_comb begin
        end_sum    = next_base + CHUNK_MAX;
        end_clip   = (end_sum > END_EXT) ? END_SEARCH : end_sum[KEY_WIDTH-1:0];
        last_chunk = (end_clip == END_SEARCH);
        do_grant   = (state == S_RUN) && !stop && pick_vld;
        do_init    = start && (state != S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_STOPPED;
                end else if (do_grant && last_chunk) begin
                    state_nxt = S_EXHAUSTED;
                end
            end
            default: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant         <= '0;
            chunk_base    <= '0;
            chunk_end     <= '0;
            chunks_issued <= '0;
            next_base     <= {1'b0, BEGIN_SEARCH};
            rr_ptr        <= '0;
        end else begin
            grant <= do_grant ? pick_onehot : '0;
            if (do_init) begin
                next_base     <= {1'b0, BEGIN_SEARCH};
                rr_ptr        <= '0;
                chunks_issued <= '0;
            end else if (do_grant) begin
                chunk_base <= next_base[KEY_WIDTH-1:0];
                chunk_end  <= end_clip;
                rr_ptr     <= pick_ptr_nxt;
                next_base  <= next_base + CHUNK_SIZE;
                if (chunks_issued != 16'hFFFF) begin
                    chunks_issued <= chunks_issued + 16'd1;
                end
            end
        end
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_STOPPED) || (state == S_EXHAUSTED);
    assign exhausted = (state == S_EXHAUSTED);

endmodule
